// File: rtl/qdiv_hs.sv
// Iterative sign-magnitude (Q,N) fixed-point divider with start/ready/valid handshake.
// Define QDIV_SATURATE_EN to saturate the magnitude on overflow instead of wrapping.
module qdiv_hs #(
  parameter int unsigned Q = 15,
  parameter int unsigned N = 32
) (
  input  logic         i_clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic         o_ready,
  output logic         o_valid,
  output logic [N-1:0] o_quotient,
  output logic         o_overflow,
  output logic         o_dbz
);

  localparam int unsigned MW = N - 1;      // magnitude width
  localparam int unsigned W  = N - 1 + Q;  // scaled dividend / full quotient width
  localparam int unsigned CW = $clog2(W);

  typedef enum logic {
    S_IDLE,
    S_CALC
  } state_t;

  state_t         state_q, state_d;
  logic           sign_q, sign_d;
  logic [W-1:0]   a_q, a_d;
  logic [MW-1:0]  b_q, b_d;
  logic [MW-1:0]  r_q, r_d;
  logic [W-2:0]   q_q, q_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ready_q, ready_d;
  logic           valid_q, valid_d;
  logic [N-1:0]   quot_q, quot_d;
  logic           ovf_q, ovf_d;
  logic           dbz_q, dbz_d;

  // One restoring step: shift next dividend bit into the partial remainder.
  logic [N-1:0]   r_sh;
  logic [MW-1:0]  r_sub;
  logic           q_bit;
  logic [W-1:0]   q_full;
  logic           ovf;
  logic [MW-1:0]  mag;

  always_comb begin
    r_sh   = {r_q, a_q[W-1]};
    q_bit  = (r_sh >= {1'b0, b_q});
    r_sub  = r_sh[MW-1:0] - b_q;
    q_full = {q_q, q_bit};
    ovf    = |q_full[W-1:MW];
`ifdef QDIV_SATURATE_EN
    mag    = ovf ? {MW{1'b1}} : q_full[MW-1:0];
`else
    mag    = q_full[MW-1:0];
`endif
  end

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    valid_d = 1'b0;
    quot_d  = quot_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (i_start && ready_q) begin
          if (i_divisor[MW-1:0] == '0) begin
            // Divide-by-zero completes on the accepting edge without leaving IDLE.
            valid_d = 1'b1;
            quot_d  = {i_dividend[N-1], {MW{1'b1}}};
            ovf_d   = 1'b0;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_CALC;
            ready_d = 1'b0;
            sign_d  = i_dividend[N-1] ^ i_divisor[N-1];
            a_d     = {i_dividend[MW-1:0], {Q{1'b0}}};
            b_d     = i_divisor[MW-1:0];
            r_d     = '0;
            q_d     = '0;
            cnt_d   = CW'(W - 1);
          end
        end
      end
      S_CALC: begin
        r_d   = q_bit ? r_sub : r_sh[MW-1:0];
        a_d   = {a_q[W-2:0], 1'b0};
        q_d   = q_full[W-2:0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
          valid_d = 1'b1;
          quot_d  = {(mag != '0) ? sign_q : 1'b0, mag};
          ovf_d   = ovf;
          dbz_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sign_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      quot_q  <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      quot_q  <= quot_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  assign o_ready    = ready_q;
  assign o_valid    = valid_q;
  assign o_quotient = quot_q;
  assign o_overflow = ovf_q;
  assign o_dbz      = dbz_q;

endmodule

// File: tb/tb_qdiv_hs.sv
// Directed, table-driven bench for qdiv_hs at the default (Q=15, N=32) configuration.
module tb_qdiv_hs;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic [31:0] i_dividend;
  logic [31:0] i_divisor;
  logic        o_ready;
  logic        o_valid;
  logic [31:0] o_quotient;
  logic        o_overflow;
  logic        o_dbz;

  int n_cmp = 0;
  int n_err = 0;

  qdiv_hs #(.Q(15), .N(32)) dut (
    .i_clk      (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_dividend (i_dividend),
    .i_divisor  (i_divisor),
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .o_quotient (o_quotient),
    .o_overflow (o_overflow),
    .o_dbz      (o_dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q_wrap;
    logic [31:0] q_sat;
    logic        ovf;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string name, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] q_wrap, input logic [31:0] q_sat,
                     input logic ovf, input logic dbz, input int lat);
    vec_t v;
    v.name = name; v.a = a; v.b = b; v.q_wrap = q_wrap; v.q_sat = q_sat;
    v.ovf = ovf; v.dbz = dbz; v.lat = lat;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive operands at the falling edge; returns #1 after the accepting edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    i_dividend = a;
    i_divisor  = b;
    i_start    = 1'b1;
    @(posedge clk);
    #1;
    i_start    = 1'b0;
    i_dividend = 32'hDEADBEEF;
    i_divisor  = 32'h0;
  endtask

  // Count edges after acceptance until o_valid is seen; optionally inject a start mid-run.
  task automatic wait_valid(input int inject_at, output int lat);
    lat = 0;
    while (o_valid !== 1'b1 && lat < 200) begin
      if (lat == inject_at) begin
        i_start    = 1'b1;
        i_dividend = 32'h00008000;
        i_divisor  = 32'h00000000;
      end
      @(posedge clk);
      #1;
      i_start = 1'b0;
      lat++;
    end
  endtask

  function automatic logic [31:0] pick(input vec_t v);
`ifdef QDIV_SATURATE_EN
    return v.q_sat;
`else
    return v.q_wrap;
`endif
  endfunction

  initial begin
    int lat;
    int vcount;
    logic [31:0] exp_q;

    rst = 1'b1; i_start = 1'b0; i_dividend = '0; i_divisor = '0;

    add("3/2",         32'h00018000, 32'h00010000, 32'h0000C000, 32'h0000C000, 1'b0, 1'b0, 46);
    add("-3/2",        32'h80018000, 32'h00010000, 32'h8000C000, 32'h8000C000, 1'b0, 1'b0, 46);
    add("-3/-2",       32'h80018000, 32'h80010000, 32'h0000C000, 32'h0000C000, 1'b0, 1'b0, 46);
    add("3/-2",        32'h00018000, 32'h80010000, 32'h8000C000, 32'h8000C000, 1'b0, 1'b0, 46);
    add("one_third",   32'h00008000, 32'h00018000, 32'h00002AAA, 32'h00002AAA, 1'b0, 1'b0, 46);
    add("neg_half_qtr",32'h80004000, 32'h00002000, 32'h80010000, 32'h80010000, 1'b0, 1'b0, 46);
    add("neg_zero",    32'h80000000, 32'h00010000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 46);
    add("trunc_zero",  32'h80000001, 32'h7FFF0000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 46);
    add("max_no_ovf",  32'h7FFFFFFF, 32'h00008000, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0, 46);
    add("ovf_edge",    32'h00010000, 32'h00000001, 32'h00000000, 32'h7FFFFFFF, 1'b1, 1'b0, 46);
    add("ovf_pos",     32'h7FFF8000, 32'h00000001, 32'h40000000, 32'h7FFFFFFF, 1'b1, 1'b0, 46);
    add("ovf_neg",     32'hFFFF8000, 32'h00000001, 32'hC0000000, 32'hFFFFFFFF, 1'b1, 1'b0, 46);
    add("dbz_pos",     32'h00008000, 32'h00000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b1, 0);
    add("dbz_neg",     32'h80008000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready",   o_ready,    1'b1);
    chk("rst_valid",   o_valid,    1'b0);
    chk("rst_quot",    o_quotient, 32'h0);
    chk("rst_ovf",     o_overflow, 1'b0);
    chk("rst_dbz",     o_dbz,      1'b0);
    @(negedge clk);
    rst = 1'b0;

    vcount = vq.size();
    for (int i = 0; i < vcount; i++) begin
      exp_q = pick(vq[i]);
      start_op(vq[i].a, vq[i].b);
      chk({vq[i].name, "_ready_after_accept"}, o_ready, vq[i].dbz);
      wait_valid(-1, lat);
      chk({vq[i].name, "_latency"}, lat,        vq[i].lat);
      chk({vq[i].name, "_quot"},    o_quotient, exp_q);
      chk({vq[i].name, "_ovf"},     o_overflow, vq[i].ovf);
      chk({vq[i].name, "_dbz"},     o_dbz,      vq[i].dbz);
      chk({vq[i].name, "_ready"},   o_ready,    1'b1);
      @(posedge clk);
      #1;
      chk({vq[i].name, "_valid_pulse"}, o_valid, 1'b0);
      chk({vq[i].name, "_hold"},        o_quotient, exp_q);
    end

    // Start pulsed mid-calculation must be ignored.
    start_op(32'h00018000, 32'h00010000);
    wait_valid(5, lat);
    chk("busy_start_latency", lat,        46);
    chk("busy_start_quot",    o_quotient, 32'h0000C000);
    chk("busy_start_dbz",     o_dbz,      1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("busy_start_no_extra_valid", o_valid, 1'b0);

    // Back-to-back: second start accepted on the edge after completion.
    start_op(32'h80018000, 32'h00010000);
    wait_valid(-1, lat);
    chk("b2b_first_quot", o_quotient, 32'h8000C000);
    start_op(32'h00008000, 32'h00018000);
    chk("b2b_second_accepted", o_ready,    1'b0);
    chk("b2b_valid_low",       o_valid,    1'b0);
    chk("b2b_first_held",      o_quotient, 32'h8000C000);
    wait_valid(-1, lat);
    chk("b2b_second_latency",  lat,        46);
    chk("b2b_second_quot",     o_quotient, 32'h00002AAA);

    // Leave dbz set so the abort check below sees nonzero outputs return to reset.
    start_op(32'h00008000, 32'h00000000);
    chk("pre_abort_dbz", o_dbz, 1'b1);
    start_op(32'h00018000, 32'h00010000);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_ready", o_ready,    1'b1);
    chk("abort_valid", o_valid,    1'b0);
    chk("abort_quot",  o_quotient, 32'h0);
    chk("abort_ovf",   o_overflow, 1'b0);
    chk("abort_dbz",   o_dbz,      1'b0);
    lat = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      if (o_valid === 1'b1) lat++;
    end
    chk("abort_no_valid", lat, 0);

    // Reset and start on the same edge: start is dropped.
    @(negedge clk);
    rst = 1'b1; i_start = 1'b1; i_dividend = 32'h00018000; i_divisor = 32'h00010000;
    @(posedge clk);
    #1;
    rst = 1'b0; i_start = 1'b0;
    chk("rst_start_ready", o_ready, 1'b1);
    lat = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      if (o_valid === 1'b1 || o_ready !== 1'b1) lat++;
    end
    chk("rst_start_dropped", lat, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
